// File: rtl/uart_axi_bridge.sv
// AXI4 slave exposing UART DATA/STAT registers over a byte PHY; AR to first R beat is 2 cycles, W beats to DATA stall while the TX holding register is full.
// Define UART_RX_OVERFLOW_EN to add a sticky RX overflow flag in STAT bit2.
module uart_axi_bridge #(
   parameter int          RX_DEPTH  = 16,
   parameter logic [31:0] BASE_ADDR = 32'hBFD003F8,
   parameter int          ID_W      = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [ID_W-1:0] ar_id,
   input  logic [31:0]     ar_addr,
   input  logic [7:0]      ar_len,
   input  logic [2:0]      ar_size,
   input  logic [1:0]      ar_burst,
   input  logic            ar_valid,
   output logic            ar_ready,
   output logic [ID_W-1:0] r_id,
   output logic [1:0]      r_resp,
   output logic [31:0]     r_data,
   output logic            r_last,
   output logic            r_valid,
   input  logic            r_ready,
   input  logic [ID_W-1:0] aw_id,
   input  logic [31:0]     aw_addr,
   input  logic [7:0]      aw_len,
   input  logic [2:0]      aw_size,
   input  logic [1:0]      aw_burst,
   input  logic            aw_valid,
   output logic            aw_ready,
   input  logic [31:0]     w_data,
   input  logic [3:0]      w_strb,
   input  logic            w_last,
   input  logic            w_valid,
   output logic            w_ready,
   output logic [ID_W-1:0] b_id,
   output logic [1:0]      b_resp,
   output logic            b_valid,
   input  logic            b_ready,
   output logic [7:0]      tx_data,
   output logic            tx_start,
   input  logic            tx_busy,
   input  logic [7:0]      rx_data,
   input  logic            rx_valid
);

   localparam int             PTR_W    = $clog2(RX_DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(RX_DEPTH);
   localparam logic [PTR_W:0] CNT_ONE  = (PTR_W+1)'(1);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [29:0]    DATA_WA  = BASE_ADDR[31:2];
   localparam logic [29:0]    STAT_WA  = BASE_ADDR[31:2] + 30'd1;
   localparam logic [1:0]     RESP_OKAY   = 2'b00;
   localparam logic [1:0]     RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {SEL_NONE, SEL_DATA, SEL_STAT} sel_t;
   typedef enum logic [1:0] {R_IDLE, R_LOAD, R_DATA} rd_state_t;
   typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;

   typedef struct packed {
      sel_t       sel;
      logic [7:0] len;
      logic [7:0] beat;
   } rd_ctx_t;

   function automatic sel_t decode(input logic [31:0] addr);
      if (addr[31:2] == DATA_WA)      return SEL_DATA;
      else if (addr[31:2] == STAT_WA) return SEL_STAT;
      else                            return SEL_NONE;
   endfunction

   rd_state_t rd_state;
   rd_ctx_t   rd_ctx;
   wr_state_t wr_state;
   sel_t      wr_sel;

   logic [7:0]       rx_mem [RX_DEPTH];
   logic [PTR_W-1:0] rx_wr_ptr;
   logic [PTR_W-1:0] rx_rd_ptr;
   logic [PTR_W:0]   rx_count;
   logic             rx_full;
   logic             rx_empty;
   logic             rx_push;
   logic             rx_pop;

   logic [7:0] tx_hold;
   logic       tx_full;
   logic       tx_load;
   logic       ovf_bit;
   logic [31:0] beat_value;

   // RX FIFO: a push into a full FIFO only lands when the same cycle pops
   assign rx_full  = (rx_count == FULL_CNT);
   assign rx_empty = (rx_count == '0);
   assign rx_pop   = (rd_state == R_LOAD) && (rd_ctx.sel == SEL_DATA) && !rx_empty;
   assign rx_push  = rx_valid && (!rx_full || rx_pop);

   always_ff @(posedge clk) begin
      if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_wr_ptr <= '0;
         rx_rd_ptr <= '0;
         rx_count  <= '0;
      end else begin
         if (rx_push) rx_wr_ptr <= rx_wr_ptr + PTR_ONE;
         if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PTR_ONE;
         case ({rx_push, rx_pop})
            2'b10:   rx_count <= rx_count + CNT_ONE;
            2'b01:   rx_count <= rx_count - CNT_ONE;
            default: rx_count <= rx_count;
         endcase
      end
   end

`ifdef UART_RX_OVERFLOW_EN
   logic ovf_flag;

   // set beats clear so a drop in the same cycle as a STAT sample is not lost
   always_ff @(posedge clk) begin
      if (rst)
         ovf_flag <= 1'b0;
      else if (rx_valid && rx_full && !rx_pop)
         ovf_flag <= 1'b1;
      else if ((rd_state == R_LOAD) && (rd_ctx.sel == SEL_STAT))
         ovf_flag <= 1'b0;
   end

   assign ovf_bit = ovf_flag;
`else
   assign ovf_bit = 1'b0;
`endif

   always_comb begin
      beat_value = 32'd0;
      case (rd_ctx.sel)
         SEL_DATA: if (!rx_empty) beat_value = {24'd0, rx_mem[rx_rd_ptr]};
         SEL_STAT: beat_value = {29'd0, ovf_bit, !rx_empty, !tx_full};
         default:  beat_value = 32'd0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_state <= R_IDLE;
         rd_ctx   <= '{sel: SEL_NONE, len: 8'd0, beat: 8'd0};
         ar_ready <= 1'b1;
         r_valid  <= 1'b0;
         r_id     <= '0;
         r_resp   <= RESP_OKAY;
         r_data   <= 32'd0;
         r_last   <= 1'b0;
      end else begin
         case (rd_state)
            R_IDLE: begin
               if (ar_valid && ar_ready) begin
                  r_id     <= ar_id;
                  rd_ctx   <= '{sel: decode(ar_addr), len: ar_len, beat: 8'd0};
                  ar_ready <= 1'b0;
                  rd_state <= R_LOAD;
               end
            end
            R_LOAD: begin
               r_data   <= beat_value;
               r_resp   <= (rd_ctx.sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
               r_last   <= (rd_ctx.beat == rd_ctx.len);
               r_valid  <= 1'b1;
               rd_state <= R_DATA;
            end
            R_DATA: begin
               if (r_ready) begin
                  r_valid <= 1'b0;
                  if (r_last) begin
                     ar_ready <= 1'b1;
                     rd_state <= R_IDLE;
                  end else begin
                     rd_ctx.beat <= rd_ctx.beat + 8'd1;
                     rd_state    <= R_LOAD;
                  end
               end
            end
            default: rd_state <= R_IDLE;
         endcase
      end
   end

   // w_ready must follow w_strb of the presented beat, so it is decoded live
   assign w_ready = (wr_state == W_DATA) && !((wr_sel == SEL_DATA) && w_strb[0] && tx_full);
   assign tx_load = w_valid && w_ready && (wr_sel == SEL_DATA) && w_strb[0];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state <= W_IDLE;
         wr_sel   <= SEL_NONE;
         aw_ready <= 1'b1;
         b_valid  <= 1'b0;
         b_id     <= '0;
         b_resp   <= RESP_OKAY;
      end else begin
         case (wr_state)
            W_IDLE: begin
               if (aw_valid && aw_ready) begin
                  b_id     <= aw_id;
                  wr_sel   <= decode(aw_addr);
                  aw_ready <= 1'b0;
                  wr_state <= W_DATA;
               end
            end
            W_DATA: begin
               if (w_valid && w_ready && w_last) begin
                  b_valid  <= 1'b1;
                  b_resp   <= (wr_sel == SEL_NONE) ? RESP_DECERR : RESP_OKAY;
                  wr_state <= W_RESP;
               end
            end
            W_RESP: begin
               if (b_ready) begin
                  b_valid  <= 1'b0;
                  aw_ready <= 1'b1;
                  wr_state <= W_IDLE;
               end
            end
            default: wr_state <= W_IDLE;
         endcase
      end
   end

   // tx_start doubles as the guard: the PHY raises busy one cycle after a launch
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_hold  <= 8'd0;
         tx_full  <= 1'b0;
         tx_start <= 1'b0;
         tx_data  <= 8'd0;
      end else begin
         tx_start <= 1'b0;
         if (tx_full && !tx_busy && !tx_start) begin
            tx_start <= 1'b1;
            tx_data  <= tx_hold;
            tx_full  <= 1'b0;
         end else if (tx_load) begin
            tx_hold <= w_data[7:0];
            tx_full <= 1'b1;
         end
      end
   end

   logic unused_ok;
   assign unused_ok = ^{ar_size, ar_burst, ar_addr[1:0], aw_size, aw_burst, aw_len,
                        aw_addr[1:0], w_data[31:8], w_strb[3:1]};

endmodule

// File: tb/tb_uart_axi_bridge.sv
// Directed plus randomized bench for uart_axi_bridge against a queue-based register model.
module tb_uart_axi_bridge;
   localparam logic [31:0] DATA_A = 32'hBFD003F8;
   localparam logic [31:0] STAT_A = 32'hBFD003FC;
   localparam logic [31:0] BAD_A  = 32'h80000000;
   localparam int DEPTH = 16;
`ifdef UART_RX_OVERFLOW_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic        clk, rst;
   logic [7:0]  ar_id, r_id, aw_id, b_id;
   logic [31:0] ar_addr, aw_addr, r_data, w_data;
   logic [7:0]  ar_len, aw_len;
   logic [2:0]  ar_size, aw_size;
   logic [1:0]  ar_burst, aw_burst, r_resp, b_resp;
   logic        ar_valid, ar_ready, r_last, r_valid, r_ready;
   logic        aw_valid, aw_ready, w_last, w_valid, w_ready, b_valid, b_ready;
   logic [3:0]  w_strb;
   logic [7:0]  tx_data, rx_data;
   logic        tx_start, tx_busy, rx_valid;
   logic        hold_busy;
   int          phy_cnt;

   logic [7:0] rxq[$];
   logic [7:0] tx_wr[$];
   logic [7:0] tx_seen[$];
   bit         m_ovf;
   int         tx_cmp;
   int         n_checks, n_fail;

   uart_axi_bridge dut (
      .clk(clk), .rst(rst),
      .ar_id(ar_id), .ar_addr(ar_addr), .ar_len(ar_len), .ar_size(ar_size), .ar_burst(ar_burst),
      .ar_valid(ar_valid), .ar_ready(ar_ready),
      .r_id(r_id), .r_resp(r_resp), .r_data(r_data), .r_last(r_last), .r_valid(r_valid), .r_ready(r_ready),
      .aw_id(aw_id), .aw_addr(aw_addr), .aw_len(aw_len), .aw_size(aw_size), .aw_burst(aw_burst),
      .aw_valid(aw_valid), .aw_ready(aw_ready),
      .w_data(w_data), .w_strb(w_strb), .w_last(w_last), .w_valid(w_valid), .w_ready(w_ready),
      .b_id(b_id), .b_resp(b_resp), .b_valid(b_valid), .b_ready(b_ready),
      .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
      .rx_data(rx_data), .rx_valid(rx_valid)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // PHY stand-in: busy for a few cycles after each launch, optionally held busy
   assign tx_busy = hold_busy || (phy_cnt != 0);
   always @(posedge clk) begin
      if (rst) phy_cnt <= 0;
      else if (tx_start) phy_cnt <= 4;
      else if (phy_cnt != 0) phy_cnt <= phy_cnt - 1;
   end

   always @(posedge clk) begin
      #2;
      if (tx_start) tx_seen.push_back(tx_data);
   end

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "simulation did not finish");
   end

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_push(input logic [7:0] b);
      if (rxq.size() < DEPTH) rxq.push_back(b);
      else m_ovf = 1'b1;
   endtask

   task automatic model_beat(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] resp);
      d = 32'd0;
      resp = 2'b00;
      if ((addr & ~32'h3) == DATA_A) begin
         if (rxq.size() > 0) d = {24'd0, rxq.pop_front()};
      end else if ((addr & ~32'h3) == DATA_A + 32'd4) begin
         d = {29'd0, (OVF_EN && m_ovf), (rxq.size() != 0), (tx_wr.size() == tx_seen.size())};
         m_ovf = 1'b0;
      end else begin
         resp = 2'b11;
      end
   endtask

   task automatic rx_push(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
      model_push(b);
   endtask

   task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input string tag,
                          input bit do_push = 1'b0, input logic [7:0] pb = 8'h00);
      logic [31:0] exp_d;
      logic [1:0]  exp_r;
      logic [7:0]  id;
      int waitc;
      id = 8'($urandom);
      ar_id = id; ar_addr = addr; ar_len = len; ar_size = 3'd2; ar_burst = 2'd1;
      ar_valid = 1'b1;
      waitc = 0;
      while (!ar_ready && waitc < 50) begin tick(); waitc++; end
      chk({tag, "_arrdy"}, ar_ready, 1);
      tick();
      ar_valid = 1'b0;
      r_ready  = 1'b1;
      chk({tag, "_load"}, r_valid, 0);
      // this cycle is the first load: the model pops here, then any same-cycle push lands
      model_beat(addr, exp_d, exp_r);
      if (do_push) begin
         rx_data = pb; rx_valid = 1'b1;
         model_push(pb);
      end
      tick();
      rx_valid = 1'b0;
      waitc = 1;
      while (!r_valid && waitc < 50) begin tick(); waitc++; end
      chk({tag, "_lat"}, waitc, 1);
      for (int b = 0; b <= int'(len); b++) begin
         if (b > 0) begin
            model_beat(addr, exp_d, exp_r);
            waitc = 0;
            while (!r_valid && waitc < 50) begin tick(); waitc++; end
            chk({tag, "_rvld"}, r_valid, 1);
         end
         chk($sformatf("%s_data%0d", tag, b), r_data, exp_d);
         chk($sformatf("%s_resp%0d", tag, b), r_resp, exp_r);
         chk($sformatf("%s_last%0d", tag, b), r_last, (b == int'(len)));
         chk($sformatf("%s_id%0d", tag, b), r_id, id);
         tick();
      end
      r_ready = 1'b0;
   endtask

   task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input int stall, input string tag);
      logic [7:0] id;
      int waitc;
      id = 8'($urandom);
      aw_id = id; aw_addr = addr; aw_len = 8'd0; aw_size = 3'd2; aw_burst = 2'd1;
      aw_valid = 1'b1;
      waitc = 0;
      while (!aw_ready && waitc < 50) begin tick(); waitc++; end
      chk({tag, "_awrdy"}, aw_ready, 1);
      tick();
      aw_valid = 1'b0;
      w_data = data; w_strb = strb; w_last = 1'b1; w_valid = 1'b1;
      if (stall > 0) begin
         for (int i = 0; i < stall; i++) begin
            chk({tag, "_stall"}, w_ready, 0);
            tick();
         end
         hold_busy = 1'b0;
      end
      waitc = 0;
      while (!w_ready && waitc < 50) begin tick(); waitc++; end
      chk({tag, "_wrdy"}, w_ready, 1);
      tick();
      w_valid = 1'b0; w_last = 1'b0;
      if (((addr & ~32'h3) == DATA_A) && strb[0]) tx_wr.push_back(data[7:0]);
      b_ready = 1'b1;
      waitc = 0;
      while (!b_valid && waitc < 50) begin tick(); waitc++; end
      chk({tag, "_bvld"}, b_valid, 1);
      chk({tag, "_bresp"}, b_resp, (((addr & ~32'h3) == DATA_A) || ((addr & ~32'h3) == STAT_A)) ? 2'b00 : 2'b11);
      chk({tag, "_bid"}, b_id, id);
      tick();
      b_ready = 1'b0;
   endtask

   task automatic tx_drain(input string tag);
      int waitc;
      waitc = 0;
      while (tx_seen.size() != tx_wr.size() && waitc < 100) begin tick(); waitc++; end
      chk({tag, "_txcnt"}, tx_seen.size(), tx_wr.size());
      for (int i = tx_cmp; i < tx_seen.size() && i < tx_wr.size(); i++)
         chk($sformatf("%s_tx%0d", tag, i), tx_seen[i], tx_wr[i]);
      tx_cmp = tx_seen.size();
   endtask

   initial begin
      logic [31:0] a;
      int waitc;
      n_checks = 0; n_fail = 0; tx_cmp = 0; m_ovf = 1'b0;
      rst = 1'b1; hold_busy = 1'b0;
      ar_id = '0; ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_valid = 1'b0; r_ready = 1'b0;
      aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_valid = 1'b0;
      w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0;
      rx_data = '0; rx_valid = 1'b0;
      repeat (3) tick();
      chk("rst_ar_ready", ar_ready, 1);
      chk("rst_aw_ready", aw_ready, 1);
      chk("rst_r_valid", r_valid, 0);
      chk("rst_w_ready", w_ready, 0);
      chk("rst_b_valid", b_valid, 0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_r_data", r_data, 0);
      chk("rst_tx_data", tx_data, 0);
      rst = 1'b0;
      tick();

      do_read(STAT_A, 8'd0, "stat0");
      rx_push(8'h5A);
      do_read(DATA_A, 8'd0, "rd5a");
      do_read(DATA_A, 8'd0, "rdempty");
      do_read(STAT_A, 8'd0, "statempty");

      hold_busy = 1'b1;
      do_write(DATA_A, 32'h0000_0041, 4'hF, 0, "w41");
      do_read(STAT_A, 8'd0, "stat_txfull");
      chk("tx_held", tx_seen.size(), 0);
      do_write(DATA_A, 32'h0000_0042, 4'h1, 3, "w42");
      tx_drain("txbp");
      do_write(DATA_A, 32'h0000_0099, 4'hE, 0, "wnostrb");
      do_write(STAT_A, 32'h0000_00FF, 4'hF, 0, "wstat");
      tx_drain("txdisc");

      for (int i = 0; i < DEPTH + 1; i++) rx_push(8'($urandom));
      do_read(STAT_A, 8'd0, "stat_ovf");
      do_read(STAT_A, 8'd0, "stat_ovf2");
      do_read(DATA_A, 8'(DEPTH - 1), "drain16");
      do_read(DATA_A, 8'd0, "drainempty");

      for (int i = 0; i < DEPTH; i++) rx_push(8'($urandom));
      do_read(DATA_A, 8'd0, "fullpushpop", 1'b1, 8'hC3);
      do_read(STAT_A, 8'd0, "stat_pp");
      do_read(DATA_A, 8'(DEPTH - 1), "drain_pp");

      rx_push(8'($urandom));
      do_read(BAD_A, 8'd3, "unmap_rd");
      do_write(BAD_A, 32'h0000_0055, 4'hF, 0, "unmap_wr");
      do_read(DATA_A, 8'd0, "after_unmap");
      tx_drain("txunmap");

      for (int it = 0; it < 8; it++) begin
         for (int k = 0; k < int'($urandom_range(0, 5)); k++) rx_push(8'($urandom));
         case ($urandom_range(0, 3))
            0: a = STAT_A;
            1: a = BAD_A + {$urandom_range(0, 255), 2'b00};
            default: a = DATA_A;
         endcase
         do_read(a, 8'($urandom_range(0, 3)), $sformatf("rnd%0d", it));
         if ($urandom_range(0, 1) == 1)
            do_write(DATA_A, $urandom, 4'($urandom), 0, $sformatf("rndw%0d", it));
         tx_drain($sformatf("rndtx%0d", it));
      end

      rx_push(8'($urandom));
      ar_id = 8'h11; ar_addr = STAT_A; ar_len = 8'd0; ar_valid = 1'b1; r_ready = 1'b0;
      tick();
      ar_valid = 1'b0;
      waitc = 0;
      while (!r_valid && waitc < 50) begin tick(); waitc++; end
      chk("prerst_rvld", r_valid, 1);
      rst = 1'b1;
      tick();
      chk("midrst_rvld", r_valid, 0);
      chk("midrst_arrdy", ar_ready, 1);
      rst = 1'b0;
      rxq.delete();
      m_ovf = 1'b0;
      tick();
      do_read(STAT_A, 8'd0, "postrst_stat");
      do_read(DATA_A, 8'd0, "postrst_data");

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
